sdram_line_cache: RTL and testbench
===================================

SDRAM_LINE_CACHE -- requirements
Module: sdram_line_cache

Interface
REQ-001 Parameters: ADDR_W=22, word address width; DATA_W=16, word width; BURST_LEN=8, words per line (power of 2); INDEX_BITS=4, set index width; WAYS=2, associativity (1 or 2).
REQ-002 CLK  in  1  sole clock; all logic on rising edge.
REQ-003 RESET_IN  in  1  synchronous, active-high reset.
REQ-004 UP_REQ_IN  in  1  upstream request, level, held until UP_ACK_OUT.
REQ-005 UP_WRITE_IN  in  1  1=write, 0=read.
REQ-006 UP_ADDR_IN  in  ADDR_W  word address.
REQ-007 UP_WDATA_IN  in  DATA_W  write data; UP_BE_IN  in  DATA_W/8  byte enables.
REQ-008 UP_ACK_OUT  out  1  one-cycle completion pulse; UP_RDATA_OUT  out  DATA_W  read data, valid with ack.
REQ-009 FLUSH_IN  in  1  flush request pulse; FLUSH_DONE_OUT  out  1  one-cycle completion pulse.
REQ-010 DST_REQ_OUT, DST_WRITE_OUT  out  1  downstream burst request/direction; DST_ADDR_OUT  out  ADDR_W  line-aligned word address; DST_ACK_IN  in  1  burst accepted.
REQ-011 DST_WDATA_OUT  out  DATA_W  write-back beat; DST_WBEAT_IN  in  1  current beat consumed.
REQ-012 DST_RDATA_IN  in  DATA_W, DST_RVALID_IN  in  1  fill beat.

Function
REQ-013 Address split: offset = low log2(BURST_LEN) bits, index = next INDEX_BITS, tag = remainder.
REQ-014 Per set/way: valid, dirty, tag; per set: one LRU bit (WAYS=2; points to least recently used way).
REQ-015 States: IDLE, LOOKUP, RESP, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, FLUSH_SCAN.
REQ-016 IDLE: pending flush has priority; else UP_REQ_IN=1 registers request, next state LOOKUP.
REQ-017 Hit: UP_ACK_OUT pulses exactly 2 cycles after request sampled; read returns stored word; write merges enabled bytes, sets dirty; LRU updated to other way.
REQ-018 RESP lasts one cycle, returns to IDLE; held UP_REQ_IN sampled again only in IDLE.
REQ-019 Miss victim: lowest-numbered invalid way, else LRU way.
REQ-020 Victim valid and dirty: WB_REQ (DST_REQ_OUT=1, DST_WRITE_OUT=1, DST_ADDR_OUT={victim tag,index,0}) until DST_ACK_IN; WB_DATA presents words 0..BURST_LEN-1, advancing on DST_WBEAT_IN; after last beat goes to FILL_REQ. Otherwise directly FILL_REQ.
REQ-021 FILL_REQ: DST_REQ_OUT=1, DST_WRITE_OUT=0, request line address, until DST_ACK_IN; FILL_DATA stores DST_RDATA_IN per DST_RVALID_IN into words 0..BURST_LEN-1; after last: valid=1, dirty=0, tag written, re-enter LOOKUP (guaranteed hit).
REQ-022 DST_REQ_OUT drops the cycle after DST_ACK_IN; DST_ACK_IN, DST_WBEAT_IN, DST_RVALID_IN ignored in any other state.
REQ-023 Stalls of any length on DST_ACK_IN, DST_WBEAT_IN, DST_RVALID_IN tolerated without data loss.
REQ-024 FLUSH_IN in any state latches pending flush; serviced at next IDLE.
REQ-025 FLUSH_SCAN walks set 0..2^INDEX_BITS-1, way 0..WAYS-1; each valid dirty line written back per REQ-020, then dirty cleared, valid kept; FLUSH_DONE_OUT pulses after last entry, returns IDLE.
REQ-026 Flush with no dirty lines completes within 2^INDEX_BITS*WAYS+2 cycles, no DST_REQ_OUT.

Reset
REQ-027 RESET_IN clears all valid, dirty, LRU bits, pending flush; state IDLE.
REQ-028 Reset values: UP_ACK_OUT, FLUSH_DONE_OUT, DST_REQ_OUT, DST_WRITE_OUT 0; DST_ADDR_OUT, UP_RDATA_OUT, DST_WDATA_OUT 0.
REQ-029 Reset mid-operation abandons burst; DST_REQ_OUT 0 on cycle after reset sampled; partly filled line stays invalid.

Verification
REQ-030 Reset, read 0x000013 -> fill request addr 0x000010; beats 0x1000..0x1007 -> ack with 0x1003; read 0x000011 -> ack 2 cycles later with 0x1001, no DST_REQ_OUT.
REQ-031 Then write 0x000011 data 0xABCD BE=01 -> hit ack; read 0x000011 -> 0x10CD.
REQ-032 Dirty 0x000010 line, read 0x000090 (same set), read 0x000110 -> write-back burst to 0x000010 carrying 0x1000,0x10CD,0x1002..0x1007, then fill of 0x000110.
REQ-033 Two dirty lines, FLUSH_IN -> two write bursts, one FLUSH_DONE_OUT pulse; second flush -> no DST_REQ_OUT, done within 34 cycles.
REQ-034 RESET_IN during fill beat 4 -> DST_REQ_OUT 0 next cycle; later read to same line issues new fill.
REQ-035 DST_ACK_IN delayed 10 cycles, DST_WBEAT_IN toggled every other cycle -> identical data and addresses as unstalled run.

Source files
------------

// File: rtl/sdram_line_cache.sv
// ---------------------------------------------------------------------------
// sdram_line_cache
//
// Write-back, write-allocate line cache between an upstream word port and a
// downstream burst port (typically an SDRAM controller). Lines are BURST_LEN
// words. The cache is direct-mapped or 2-way set associative, with one LRU
// bit per set. A flush walks every set/way and writes back all dirty lines.
//
// Ports
//   clk, reset              sole clock (rising edge), synchronous active-high
//   up_req/up_write         upstream request (level, held until up_ack)
//   up_addr/up_wdata/up_be  word address, write data, byte enables
//   up_ack/up_rdata         one-cycle completion pulse, read data with ack
//   flush/flush_done        flush request pulse, one-cycle completion pulse
//   dst_req/dst_write       downstream burst request and direction
//   dst_addr                line-aligned word address of the burst
//   dst_ack                 burst accepted
//   dst_wdata/dst_wbeat     write-back beat and its consume strobe
//   dst_rdata/dst_rvalid    fill beat and its valid strobe
// ---------------------------------------------------------------------------
module sdram_line_cache #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 8,
    parameter int INDEX_BITS = 4,
    parameter int WAYS       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                up_req,
    input  logic                up_write,
    input  logic [ADDR_W-1:0]   up_addr,
    input  logic [DATA_W-1:0]   up_wdata,
    input  logic [DATA_W/8-1:0] up_be,
    output logic                up_ack,
    output logic [DATA_W-1:0]   up_rdata,
    input  logic                flush,
    output logic                flush_done,
    output logic                dst_req,
    output logic                dst_write,
    output logic [ADDR_W-1:0]   dst_addr,
    input  logic                dst_ack,
    output logic [DATA_W-1:0]   dst_wdata,
    input  logic                dst_wbeat,
    input  logic [DATA_W-1:0]   dst_rdata,
    input  logic                dst_rvalid
);

    localparam int OFF_W = $clog2(BURST_LEN);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [OFF_W-1:0]      BEAT_LAST = OFF_W'(BURST_LEN - 1);
    localparam logic [INDEX_BITS-1:0] SET_LAST  = INDEX_BITS'(SETS - 1);
    localparam logic [WAY_W-1:0]      WAY_LAST  = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RESP,
        WB_REQ,
        WB_DATA,
        FILL_REQ,
        FILL_DATA,
        FLUSH_SCAN
    } state_t;

    // Line storage and tags
    logic [DATA_W-1:0] data_mem [WAYS][SETS][BURST_LEN];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];

    // Per-entry status; lru_q[s] names the least recently used way of set s
    logic [WAYS-1:0][SETS-1:0] valid_q;
    logic [WAYS-1:0][SETS-1:0] dirty_q;
    logic [SETS-1:0]           lru_q;

    state_t state;

    // Registered upstream request
    logic                  req_write;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_idx;
    logic [OFF_W-1:0]      req_off;
    logic [DATA_W-1:0]     req_wdata;
    logic [BE_W-1:0]       req_be;

    // Line currently being written back / filled
    logic [WAY_W-1:0]      victim;
    logic [INDEX_BITS-1:0] op_idx;
    logic [OFF_W-1:0]      beat;

    // Flush bookkeeping
    logic                  flush_pend;
    logic                  flushing;
    logic [INDEX_BITS-1:0] scan_set;
    logic [WAY_W-1:0]      scan_way;

    // Lookup results
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim_sel;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged_word;

    // Helpers for beat sequencing and the flush walk
    logic [OFF_W-1:0]      beat_nxt;
    logic [DATA_W-1:0]     wb_first_word;
    logic [DATA_W-1:0]     wb_next_word;
    logic                  scan_dirty;
    logic                  scan_last;
    logic [INDEX_BITS-1:0] scan_set_nxt;
    logic [WAY_W-1:0]      scan_way_nxt;

    // Storage write strobes
    logic fill_we;
    logic hit_we;
    logic tag_we;

    // -----------------------------------------------------------------------
    // Tag compare and victim choice: lowest-numbered invalid way, else LRU.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // otherwise the tool infers a latch to hold the old value.
        hit        = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[w][req_idx]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_sel = inv_found ? inv_way : WAY_W'(lru_q[req_idx]);
    end

    // Read word and byte-merged write word for the hit way
    always_comb begin
        cur_word    = data_mem[hit_way][req_idx][req_off];
        merged_word = cur_word;
        for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) begin
                merged_word[b*8 +: 8] = req_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        beat_nxt      = beat + 1'b1;
        wb_first_word = data_mem[victim][op_idx][0];
        wb_next_word  = data_mem[victim][op_idx][beat_nxt];
        scan_dirty    = valid_q[scan_way][scan_set] && dirty_q[scan_way][scan_set];
        scan_last     = (scan_set == SET_LAST) && (scan_way == WAY_LAST);
        // Walk ways inside a set, then move to the next set
        if (scan_way == WAY_LAST) begin
            scan_way_nxt = '0;
            scan_set_nxt = scan_set + 1'b1;
        end else begin
            scan_way_nxt = scan_way + 1'b1;
            scan_set_nxt = scan_set;
        end
    end

    always_comb begin
        fill_we = !reset && (state == FILL_DATA) && dst_rvalid;
        hit_we  = !reset && (state == LOOKUP) && hit && req_write;
        tag_we  = fill_we && (beat == BEAT_LAST);
    end

    // -----------------------------------------------------------------------
    // Data and tag arrays. Validity lives in valid_q, so the arrays carry no
    // reset and can map onto plain RAM.
    // -----------------------------------------------------------------------
    // NOTE: storage arrays are deliberately not reset; a reset branch here
    // would turn every bit into a resettable flop and block RAM inference.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[victim][op_idx][beat] <= dst_rdata;
        end
        if (hit_we) begin
            data_mem[hit_way][req_idx][req_off] <= merged_word;
        end
        if (tag_we) begin
            tag_mem[victim][op_idx] <= req_tag;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            flush_pend <= 1'b0;
            flushing   <= 1'b0;
            scan_set   <= '0;
            scan_way   <= '0;
            req_write  <= 1'b0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_off    <= '0;
            req_wdata  <= '0;
            req_be     <= '0;
            victim     <= '0;
            op_idx     <= '0;
            beat       <= '0;
            up_ack     <= 1'b0;
            up_rdata   <= '0;
            flush_done <= 1'b0;
            dst_req    <= 1'b0;
            dst_write  <= 1'b0;
            dst_addr   <= '0;
            dst_wdata  <= '0;
        end else begin
            up_ack     <= 1'b0;
            flush_done <= 1'b0;

            // Latch a flush from any state; IDLE below consumes it (a later
            // assignment there overrides this one for the consuming pulse).
            if (flush) begin
                flush_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (flush_pend || flush) begin
                        flush_pend <= 1'b0;
                        flushing   <= 1'b1;
                        scan_set   <= '0;
                        scan_way   <= '0;
                        state      <= FLUSH_SCAN;
                    end else if (up_req) begin
                        req_write <= up_write;
                        req_off   <= up_addr[OFF_W-1:0];
                        req_idx   <= up_addr[OFF_W +: INDEX_BITS];
                        req_tag   <= up_addr[ADDR_W-1 -: TAG_W];
                        req_wdata <= up_wdata;
                        req_be    <= up_be;
                        state     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (hit) begin
                        if (req_write) begin
                            dirty_q[hit_way][req_idx] <= 1'b1;
                        end else begin
                            up_rdata <= cur_word;
                        end
                        if (WAYS > 1) begin
                            lru_q[req_idx] <= ~hit_way[0];
                        end
                        state <= RESP;
                    end else begin
                        victim  <= victim_sel;
                        op_idx  <= req_idx;
                        dst_req <= 1'b1;
                        if (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx]) begin
                            dst_write <= 1'b1;
                            dst_addr  <= {tag_mem[victim_sel][req_idx], req_idx, OFF_W'(0)};
                            state     <= WB_REQ;
                        end else begin
                            dst_write <= 1'b0;
                            dst_addr  <= {req_tag, req_idx, OFF_W'(0)};
                            state     <= FILL_REQ;
                        end
                    end
                end

                RESP: begin
                    up_ack <= 1'b1;
                    state  <= IDLE;
                end

                WB_REQ: begin
                    if (dst_ack) begin
                        dst_req   <= 1'b0;
                        beat      <= '0;
                        dst_wdata <= wb_first_word;
                        state     <= WB_DATA;
                    end
                end

                WB_DATA: begin
                    if (dst_wbeat) begin
                        if (beat == BEAT_LAST) begin
                            if (flushing) begin
                                // Line stays valid, now clean
                                dirty_q[victim][op_idx] <= 1'b0;
                                if (scan_last) begin
                                    flush_done <= 1'b1;
                                    flushing   <= 1'b0;
                                    state      <= IDLE;
                                end else begin
                                    scan_set <= scan_set_nxt;
                                    scan_way <= scan_way_nxt;
                                    state    <= FLUSH_SCAN;
                                end
                            end else begin
                                dst_req   <= 1'b1;
                                dst_write <= 1'b0;
                                dst_addr  <= {req_tag, req_idx, OFF_W'(0)};
                                state     <= FILL_REQ;
                            end
                        end else begin
                            beat      <= beat_nxt;
                            dst_wdata <= wb_next_word;
                        end
                    end
                end

                FILL_REQ: begin
                    if (dst_ack) begin
                        dst_req <= 1'b0;
                        beat    <= '0;
                        // The old line is gone from here on; keep the entry
                        // invalid until the last fill beat lands.
                        valid_q[victim][op_idx] <= 1'b0;
                        dirty_q[victim][op_idx] <= 1'b0;
                        state   <= FILL_DATA;
                    end
                end

                FILL_DATA: begin
                    if (dst_rvalid) begin
                        if (beat == BEAT_LAST) begin
                            valid_q[victim][op_idx] <= 1'b1;
                            dirty_q[victim][op_idx] <= 1'b0;
                            // Re-run the lookup; it now hits and serves the request
                            state <= LOOKUP;
                        end else begin
                            beat <= beat_nxt;
                        end
                    end
                end

                FLUSH_SCAN: begin
                    if (scan_dirty) begin
                        victim    <= scan_way;
                        op_idx    <= scan_set;
                        dst_req   <= 1'b1;
                        dst_write <= 1'b1;
                        dst_addr  <= {tag_mem[scan_way][scan_set], scan_set, OFF_W'(0)};
                        state     <= WB_REQ;
                    end else if (scan_last) begin
                        flush_done <= 1'b1;
                        flushing   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        scan_set <= scan_set_nxt;
                        scan_way <= scan_way_nxt;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_line_cache.sv
// ---------------------------------------------------------------------------
// tb_sdram_line_cache
//
// Directed bench for sdram_line_cache. A table of upstream transactions with
// hand-computed read data and expected downstream bursts is applied in a
// loop; flush, stalled-downstream and reset-during-fill sequences follow.
// A behavioural downstream memory answers bursts; words never written back
// read as 0x1000 + (addr - 0x10).
// ---------------------------------------------------------------------------
module tb_sdram_line_cache;

    typedef struct packed {
        logic        wr;
        logic [21:0] addr;
    } burst_t;

    typedef struct {
        logic        wr;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        int          n_bursts;
        burst_t      b0;
        burst_t      b1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        up_req;
    logic        up_write;
    logic [21:0] up_addr;
    logic [15:0] up_wdata;
    logic [1:0]  up_be;
    logic        up_ack;
    logic [15:0] up_rdata;
    logic        flush;
    logic        flush_done;
    logic        dst_req;
    logic        dst_write;
    logic [21:0] dst_addr;
    logic        dst_ack;
    logic [15:0] dst_wdata;
    logic        dst_wbeat;
    logic [15:0] dst_rdata;
    logic        dst_rvalid;

    sdram_line_cache dut (
        .clk        (clk),
        .reset      (reset),
        .up_req     (up_req),
        .up_write   (up_write),
        .up_addr    (up_addr),
        .up_wdata   (up_wdata),
        .up_be      (up_be),
        .up_ack     (up_ack),
        .up_rdata   (up_rdata),
        .flush      (flush),
        .flush_done (flush_done),
        .dst_req    (dst_req),
        .dst_write  (dst_write),
        .dst_addr   (dst_addr),
        .dst_ack    (dst_ack),
        .dst_wdata  (dst_wdata),
        .dst_wbeat  (dst_wbeat),
        .dst_rdata  (dst_rdata),
        .dst_rvalid (dst_rvalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Downstream responder configuration (written by the main sequence only)
    int ack_delay     = 0;
    int beat_gap      = 0;
    int rd_beat_limit = 8;

    // Responder state (written by the responder only)
    burst_t      burst_log[$];
    logic [15:0] wb_log[$];
    int          rd_beats_sent = 0;
    logic [15:0] dmem [logic [21:0]];

    // Monitors (written by their own always blocks only)
    int done_pulses = 0;
    int req_cycles  = 0;

    always @(negedge clk) begin
        if (flush_done) done_pulses++;
        if (dst_req) req_cycles++;
    end

    function automatic logic [15:0] init_word(input logic [21:0] a);
        return 16'h1000 + (a[15:0] - 16'h0010);
    endfunction

    function automatic burst_t bt(input logic wr, input logic [21:0] a);
        burst_t r;
        r.wr   = wr;
        r.addr = a;
        return r;
    endfunction

    function automatic vec_t mk(input logic wr, input logic [21:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be,
                                input logic [15:0] exp_rdata, input int nb,
                                input burst_t b0, input burst_t b1);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.n_bursts = nb; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Downstream memory model: logs every burst and every write-back beat
    initial begin
        burst_t      b;
        logic [21:0] a;
        dst_ack = 1'b0; dst_wbeat = 1'b0; dst_rvalid = 1'b0; dst_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset && dst_req) begin
                b.wr   = dst_write;
                b.addr = dst_addr;
                burst_log.push_back(b);
                repeat (ack_delay) begin @(posedge clk); #1; end
                dst_ack = 1'b1;
                @(posedge clk); #1;
                dst_ack = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    a = b.addr + 22'(i);
                    if (b.wr) begin
                        repeat (beat_gap) begin @(posedge clk); #1; end
                        wb_log.push_back(dst_wdata);
                        dmem[a] = dst_wdata;
                        dst_wbeat = 1'b1;
                        @(posedge clk); #1;
                        dst_wbeat = 1'b0;
                    end else begin
                        if (i >= rd_beat_limit) break;
                        repeat (beat_gap) begin @(posedge clk); #1; end
                        dst_rdata  = dmem.exists(a) ? dmem[a] : init_word(a);
                        dst_rvalid = 1'b1;
                        @(posedge clk); #1;
                        dst_rvalid = 1'b0;
                        rd_beats_sent++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1; up_req = 1'b0; flush = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          nb0;
        int          lat;
        bit          ok;
        logic [15:0] rd;
        nb0 = burst_log.size();
        ok = 1'b0; lat = 0; rd = '0;
        up_write = v.wr; up_addr = v.addr; up_wdata = v.wdata; up_be = v.be;
        up_req = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (up_ack) begin
                ok = 1'b1; lat = c; rd = up_rdata;
                break;
            end
        end
        up_req = 1'b0;
        check({tag, " ack"}, 32'(ok), 1);
        if (!v.wr) check({tag, " rdata"}, 32'(rd), 32'(v.exp_rdata));
        check({tag, " burst count"}, burst_log.size() - nb0, v.n_bursts);
        if (v.n_bursts == 0) check({tag, " hit latency"}, lat, 3);
        if (v.n_bursts >= 1 && burst_log.size() > nb0)
            check({tag, " burst0"}, 32'(burst_log[nb0]), 32'(v.b0));
        if (v.n_bursts >= 2 && burst_log.size() > nb0 + 1)
            check({tag, " burst1"}, 32'(burst_log[nb0 + 1]), 32'(v.b1));
    endtask

    task automatic do_flush(input string tag, output int lat, output bit got);
        got = 1'b0; lat = 0;
        flush = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(posedge clk); #1;
            flush = 1'b0;
            if (flush_done) begin
                got = 1'b1; lat = c;
                break;
            end
        end
        flush = 1'b0;
        check({tag, " done seen"}, 32'(got), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[11];
        burst_t      none;
        logic [15:0] exp_wb10[8];
        logic [15:0] exp_flush[16];
        int          w0, b0, d0, r0, s0, lat;
        bit          got;

        none = bt(1'b0, 22'h0);
        vecs[0]  = mk(0, 22'h013, 16'h0000, 2'b00, 16'h1003, 1, bt(0, 22'h010), none);
        vecs[1]  = mk(0, 22'h011, 16'h0000, 2'b00, 16'h1001, 0, none, none);
        vecs[2]  = mk(1, 22'h011, 16'hABCD, 2'b01, 16'h0000, 0, none, none);
        vecs[3]  = mk(0, 22'h011, 16'h0000, 2'b00, 16'h10CD, 0, none, none);
        vecs[4]  = mk(0, 22'h090, 16'h0000, 2'b00, 16'h1080, 1, bt(0, 22'h090), none);
        vecs[5]  = mk(0, 22'h110, 16'h0000, 2'b00, 16'h1100, 2, bt(1, 22'h010), bt(0, 22'h110));
        vecs[6]  = mk(0, 22'h094, 16'h0000, 2'b00, 16'h1084, 0, none, none);
        vecs[7]  = mk(1, 22'h112, 16'h5555, 2'b11, 16'h0000, 0, none, none);
        vecs[8]  = mk(1, 22'h095, 16'h6666, 2'b10, 16'h0000, 0, none, none);
        vecs[9]  = mk(0, 22'h095, 16'h0000, 2'b00, 16'h6685, 0, none, none);
        vecs[10] = mk(0, 22'h112, 16'h0000, 2'b00, 16'h5555, 0, none, none);

        for (int i = 0; i < 8; i++) begin
            exp_wb10[i]      = 16'h1000 + 16'(i);
            exp_flush[i]     = 16'h1100 + 16'(i);
            exp_flush[8 + i] = 16'h1080 + 16'(i);
        end
        exp_wb10[1]   = 16'h10CD;
        exp_flush[2]  = 16'h5555;
        exp_flush[13] = 16'h6685;

        up_write = 1'b0; up_addr = '0; up_wdata = '0; up_be = '0;

        // Reset values
        do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset up_ack",     32'(up_ack),     0);
        check("reset flush_done", 32'(flush_done), 0);
        check("reset dst_req",    32'(dst_req),    0);
        check("reset dst_write",  32'(dst_write),  0);
        check("reset dst_addr",   32'(dst_addr),   0);
        check("reset up_rdata",   32'(up_rdata),   0);
        check("reset dst_wdata",  32'(dst_wdata),  0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Main transaction table
        w0 = wb_log.size();
        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end
        check("evict wb beat count", wb_log.size() - w0, 8);
        for (int i = 0; i < 8; i++) begin
            if (wb_log.size() > w0 + i)
                check($sformatf("evict wb beat%0d", i), 32'(wb_log[w0 + i]), 32'(exp_wb10[i]));
        end

        // Flush with two dirty lines in set 2 (way0 = 0x110, way1 = 0x090)
        b0 = burst_log.size(); w0 = wb_log.size(); d0 = done_pulses;
        do_flush("flush1", lat, got);
        repeat (5) begin @(posedge clk); #1; end
        check("flush1 done pulses", done_pulses - d0, 1);
        check("flush1 burst count", burst_log.size() - b0, 2);
        if (burst_log.size() >= b0 + 2) begin
            check("flush1 burst0", 32'(burst_log[b0]),     32'(bt(1, 22'h110)));
            check("flush1 burst1", 32'(burst_log[b0 + 1]), 32'(bt(1, 22'h090)));
        end
        check("flush1 wb beat count", wb_log.size() - w0, 16);
        for (int i = 0; i < 16; i++) begin
            if (wb_log.size() > w0 + i)
                check($sformatf("flush1 beat%0d", i), 32'(wb_log[w0 + i]), 32'(exp_flush[i]));
        end

        // Second flush: nothing dirty, no downstream traffic, bounded time
        b0 = burst_log.size(); d0 = done_pulses; r0 = req_cycles;
        do_flush("flush2", lat, got);
        check("flush2 latency within 34", 32'(got && lat <= 34), 1);
        repeat (3) begin @(posedge clk); #1; end
        check("flush2 dst_req cycles", req_cycles - r0, 0);
        check("flush2 burst count", burst_log.size() - b0, 0);
        check("flush2 done pulses", done_pulses - d0, 1);

        // Same eviction with a slow downstream side
        do_reset();
        apply_vec(vecs[0], "stall vec0");
        apply_vec(vecs[2], "stall vec2");
        apply_vec(vecs[4], "stall vec4");
        ack_delay = 10; beat_gap = 1;
        w0 = wb_log.size();
        apply_vec(vecs[5], "stall vec5");
        ack_delay = 0; beat_gap = 0;
        check("stall wb beat count", wb_log.size() - w0, 8);
        for (int i = 0; i < 8; i++) begin
            if (wb_log.size() > w0 + i)
                check($sformatf("stall wb beat%0d", i), 32'(wb_log[w0 + i]), 32'(exp_wb10[i]));
        end

        // Reset while a fill is in progress (after four beats)
        rd_beat_limit = 4;
        s0 = rd_beats_sent; got = 1'b0;
        up_write = 1'b0; up_addr = 22'h200; up_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (rd_beats_sent - s0 >= 4) begin
                got = 1'b1;
                break;
            end
        end
        check("midfill four beats delivered", 32'(got), 1);
        reset = 1'b1; up_req = 1'b0;
        @(posedge clk); #1;
        check("midfill reset dst_req",   32'(dst_req),   0);
        check("midfill reset dst_write", 32'(dst_write), 0);
        check("midfill reset dst_addr",  32'(dst_addr),  0);
        check("midfill reset up_ack",    32'(up_ack),    0);
        @(posedge clk); #1;
        reset = 1'b0;
        rd_beat_limit = 8;
        @(posedge clk); #1;
        apply_vec(mk(0, 22'h200, 16'h0000, 2'b00, 16'h11F0, 1, bt(0, 22'h200), none), "refill");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
